// File: rtl/uart_rx_deserializer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_deserializer_pkg : shared state encoding for the UART receive path
// Revision 1.0
// ---------------------------------------------------------------------------
package uart_rx_deserializer_pkg;

    typedef enum logic [1:0] {
        S_RX_IDLE  = 2'd0,
        S_RX_START = 2'd1,
        S_RX_DATA  = 2'd2,
        S_RX_STOP  = 2'd3
    } RX_state_type;

endpackage
`default_nettype wire

// File: rtl/uart_rx_deserializer_bit_synchronizer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_deserializer_bit_synchronizer : two-flop synchronizer, settable reset
// Revision 1.0
// ---------------------------------------------------------------------------
module uart_rx_deserializer_bit_synchronizer #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            meta     <= RESET_VALUE;
            sync_out <= RESET_VALUE;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_deserializer : 8-N-1 UART receiver with Empty/Unload_data handshake
// Revision 1.0
// ---------------------------------------------------------------------------
module uart_rx_deserializer
    import uart_rx_deserializer_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 434
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       UART_RX_I,
    input  logic       Enable,
    input  logic       Unload_data,
    output logic [7:0] RX_data,
    output logic       Empty,
    output logic       Overrun,
    output logic       Frame_error
);

    localparam int              CW   = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF = CW'(CLOCKS_PER_BIT / 2 - 1);

    RX_state_type  state;
    logic          rx_s;
    logic          rx_prev;
    logic [CW-1:0] sample_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;

    uart_rx_deserializer_bit_synchronizer #(
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .async_in (UART_RX_I),
        .sync_out (rx_s)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state       <= S_RX_IDLE;
            rx_prev     <= 1'b1;
            sample_cnt  <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            RX_data     <= 8'h00;
            Empty       <= 1'b1;
            Overrun     <= 1'b0;
            Frame_error <= 1'b0;
        end else begin
            rx_prev <= rx_s;
            if (!Enable) begin
                state       <= S_RX_IDLE;
                sample_cnt  <= '0;
                bit_cnt     <= '0;
                Empty       <= 1'b1;
                Overrun     <= 1'b0;
                Frame_error <= 1'b0;
            end else begin
                // A completing byte in STOP below overrides this unload.
                if (Unload_data && !Empty)
                    Empty <= 1'b1;

                case (state)
                    S_RX_IDLE: begin
                        if (rx_prev && !rx_s) begin
                            sample_cnt <= '0;
                            bit_cnt    <= '0;
                            state      <= S_RX_START;
                        end
                    end
                    S_RX_START: begin
                        if (sample_cnt == HALF) begin
                            sample_cnt <= '0;
                            state      <= rx_s ? S_RX_IDLE : S_RX_DATA;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                    S_RX_DATA: begin
                        if (sample_cnt == LAST) begin
                            sample_cnt <= '0;
                            shift_reg  <= {rx_s, shift_reg[7:1]};
                            bit_cnt    <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                state <= S_RX_STOP;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                    S_RX_STOP: begin
                        if (sample_cnt == LAST) begin
                            sample_cnt <= '0;
                            state      <= S_RX_IDLE;
                            if (!rx_s) begin
                                Frame_error <= 1'b1;
                            end else if (Empty || Unload_data) begin
                                RX_data <= shift_reg;
                                Empty   <= 1'b0;
                            end else begin
                                Overrun <= 1'b1;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                    default: state <= S_RX_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_rx_deserializer : directed and randomized frames against a frame model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_uart_rx_deserializer;

    localparam int C     = 16;
    localparam int T_EXP = 2 + 1 + C/2 + 9*C + 1;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       UART_RX_I = 1'b1;
    logic       Enable = 1'b0;
    logic       Unload_data = 1'b0;
    logic [7:0] RX_data;
    logic       Empty;
    logic       Overrun;
    logic       Frame_error;

    uart_rx_deserializer #(
        .CLOCKS_PER_BIT (C)
    ) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .UART_RX_I   (UART_RX_I),
        .Enable      (Enable),
        .Unload_data (Unload_data),
        .RX_data     (RX_data),
        .Empty       (Empty),
        .Overrun     (Overrun),
        .Frame_error (Frame_error)
    );

    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;

    // Consumer-visible state, updated per whole frame / handshake event
    logic [7:0] m_data  = 8'h00;
    logic       m_empty = 1'b1;
    logic       m_ovr   = 1'b0;
    logic       m_fe    = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check_val({tag, "_data"},  {24'h0, RX_data},    {24'h0, m_data});
        check_val({tag, "_empty"}, {31'h0, Empty},      {31'h0, m_empty});
        check_val({tag, "_ovr"},   {31'h0, Overrun},    {31'h0, m_ovr});
        check_val({tag, "_fe"},    {31'h0, Frame_error}, {31'h0, m_fe});
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop)        m_fe = 1'b1;
        else if (m_empty) begin m_data = b; m_empty = 1'b0; end
        else              m_ovr = 1'b1;
    endtask

    // Called and returns at a negedge; line left idle-high afterwards
    task automatic send_frame(input logic [7:0] b, input logic stop);
        UART_RX_I = 1'b0;
        repeat (C) @(negedge Clock);
        for (int i = 0; i < 8; i++) begin
            UART_RX_I = b[i];
            repeat (C) @(negedge Clock);
        end
        UART_RX_I = stop;
        repeat (C) @(negedge Clock);
        UART_RX_I = 1'b1;
    endtask

    task automatic do_unload(input string tag);
        Unload_data = 1'b1;
        @(negedge Clock);
        Unload_data = 1'b0;
        m_empty = 1'b1;
        check_model(tag);
    endtask

    task automatic pulse_enable(input string tag);
        Enable = 1'b0;
        @(negedge Clock);
        Enable = 1'b1;
        m_empty = 1'b1; m_ovr = 1'b0; m_fe = 1'b0;
        @(negedge Clock);
        check_model(tag);
    endtask

    initial begin
        int         lat;
        logic [7:0] b;
        logic       stop;
        logic [7:0] abort_byte;

        repeat (3) @(negedge Clock);
        check_model("reset");
        Resetn = 1'b1;
        Enable = 1'b1;
        repeat (5) @(negedge Clock);

        // Basic byte with latency measurement from the pin's falling edge
        lat = 0;
        fork
            send_frame(8'h55, 1'b1);
            begin
                while (Empty && lat < 400) begin
                    @(posedge Clock);
                    #1;
                    lat++;
                end
            end
        join
        check_val("latency_in_window", {31'h0, (lat >= T_EXP-1 && lat <= T_EXP+1)}, 32'd1);
        model_frame(8'h55, 1'b1);
        check_model("basic");
        do_unload("basic_unload");

        // Overrun: two frames back-to-back without unload
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        model_frame(8'h22, 1'b1);
        check_model("overrun");
        pulse_enable("overrun_clear");

        // Frame error followed by a good byte
        send_frame(8'hA3, 1'b0);
        model_frame(8'hA3, 1'b0);
        repeat (2) @(negedge Clock);
        check_model("frame_err");
        send_frame(8'h0A, 1'b1);
        model_frame(8'h0A, 1'b1);
        check_model("after_fe");
        pulse_enable("fe_clear");

        // Glitch shorter than half a bit
        UART_RX_I = 1'b0;
        repeat (6) @(negedge Clock);
        UART_RX_I = 1'b1;
        repeat (3*C) @(negedge Clock);
        check_model("glitch");

        // Abort during bit 4 of 8'hF0, then a clean 8'h3C
        abort_byte = 8'hF0;
        UART_RX_I = 1'b0;
        repeat (C) @(negedge Clock);
        for (int i = 0; i < 4; i++) begin
            UART_RX_I = abort_byte[i];
            repeat (C) @(negedge Clock);
        end
        UART_RX_I = abort_byte[4];
        repeat (C/2) @(negedge Clock);
        Enable = 1'b0;
        repeat (4) @(negedge Clock);
        UART_RX_I = 1'b1;
        repeat (4) @(negedge Clock);
        Enable = 1'b1;
        m_empty = 1'b1; m_ovr = 1'b0; m_fe = 1'b0;
        repeat (2*C) @(negedge Clock);
        check_model("abort_idle");
        send_frame(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1);
        check_model("abort_next");
        do_unload("abort_unload");

        // Randomized frames, unloads and enable pulses
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge Clock);
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            send_frame(b, stop);
            model_frame(b, stop);
            check_model("rnd");
            if ($urandom_range(0, 1) == 1) do_unload("rnd_unload");
            if ($urandom_range(0, 9) == 0) pulse_enable("rnd_enable");
        end

        // Asynchronous reset during the data bits
        pulse_enable("pre_reset");
        send_frame(8'hC3, 1'b1);
        model_frame(8'hC3, 1'b1);
        check_model("pre_reset_byte");
        UART_RX_I = 1'b0;
        repeat (3*C) @(negedge Clock);
        @(posedge Clock);
        #2;
        Resetn = 1'b0;
        #1;
        m_data = 8'h00; m_empty = 1'b1; m_ovr = 1'b0; m_fe = 1'b0;
        check_model("async_reset");
        UART_RX_I = 1'b1;
        @(negedge Clock);
        Resetn = 1'b1;
        repeat (2) @(negedge Clock);
        check_model("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
